// File: rtl/collision_resolver_pkg.sv
// rtl/collision_resolver_pkg.sv - shared constants, state encoding and scoring helper
package collision_resolver_pkg;

  localparam int INVADERS_H   = 11;
  localparam int INVADERS_V   = 5;
  localparam int NUM_INVADERS = INVADERS_H * INVADERS_V;
  localparam int LIVES_INIT   = 3;
  localparam int HIT_FRAMES   = 60;
  localparam int SCORE_W      = 16;
  localparam int CODE_W       = 6;

  localparam logic [5:0] PTS_ROW0  = 6'd30;
  localparam logic [5:0] PTS_ROW12 = 6'd20;
  localparam logic [5:0] PTS_ROW34 = 6'd10;

  typedef enum logic [1:0] {
    ST_PLAY  = 2'd0,
    ST_HIT   = 2'd1,
    ST_CLEAR = 2'd2,
    ST_OVER  = 2'd3
  } state_t;

  // Row is (code-1)/h; compared against row boundaries to avoid a divider.
  function automatic logic [5:0] row_points(input logic [CODE_W-1:0] code, input int h);
    if (int'(code) <= h)
      return PTS_ROW0;
    else if (int'(code) <= 3 * h)
      return PTS_ROW12;
    else
      return PTS_ROW34;
  endfunction

endpackage

// File: rtl/collision_resolver_latch.sv
// rtl/collision_resolver_latch.sv - per-frame capture of pending invader and missile hits
module collision_resolver_latch
  import collision_resolver_pkg::*;
#(
  parameter int N = collision_resolver_pkg::NUM_INVADERS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              flush,
  input  logic [N-1:0]      mask,
  input  logic [CODE_W-1:0] invader_collision,
  input  logic [1:0]        player_collision,
  output logic [CODE_W-1:0] pend_inv,
  output logic [2:0]        pend_mis
);

  logic [63:0]       mask_ext;
  logic [CODE_W-1:0] idx;
  logic              code_ok;
  logic [2:0]        mis_oh;

  always_comb begin
    mask_ext = 64'(mask);
    idx      = invader_collision - 6'd1;
    code_ok  = (invader_collision != '0) && (int'(invader_collision) <= N) && mask_ext[idx];
    mis_oh   = 3'b000;
    case (player_collision)
      2'd1:    mis_oh = 3'b001;
      2'd2:    mis_oh = 3'b010;
      2'd3:    mis_oh = 3'b100;
      default: mis_oh = 3'b000;
    endcase
  end

  // On clear the latch reloads from this cycle's inputs so a same-cycle hit rolls into the next frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_inv <= '0;
      pend_mis <= '0;
    end else if (flush) begin
      pend_inv <= '0;
      pend_mis <= '0;
    end else if (clear) begin
      pend_inv <= code_ok ? invader_collision : '0;
      pend_mis <= mis_oh;
    end else begin
      if (pend_inv == '0 && code_ok)
        pend_inv <= invader_collision;
      pend_mis <= pend_mis | mis_oh;
    end
  end

endmodule

// File: rtl/collision_resolver.sv
// rtl/collision_resolver.sv - commits latched collisions once per frame into mask, score, lives and FSM
module collision_resolver #(
  parameter int INVADERS_H = collision_resolver_pkg::INVADERS_H,
  parameter int INVADERS_V = collision_resolver_pkg::INVADERS_V,
  parameter int LIVES_INIT = collision_resolver_pkg::LIVES_INIT,
  parameter int HIT_FRAMES = collision_resolver_pkg::HIT_FRAMES,
  parameter int SCORE_W    = collision_resolver_pkg::SCORE_W
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          frame,
  input  logic                          new_game,
  input  logic [5:0]                    invader_collision,
  input  logic [1:0]                    player_collision,
  output logic [INVADERS_H*INVADERS_V-1:0] invaders,
  output logic                          laser_kill,
  output logic [2:0]                    missile_kill,
  output logic [2:0]                    lives,
  output logic [SCORE_W-1:0]            score,
  output logic                          player_hit,
  output logic                          game_over,
  output logic                          wave_clear
);
  import collision_resolver_pkg::*;

  localparam int N   = INVADERS_H * INVADERS_V;
  localparam int HCW = $clog2(HIT_FRAMES + 1);

  state_t             state_q, state_d;
  logic [N-1:0]       inv_q, inv_d, mask_after;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [2:0]         lives_q, lives_d;
  logic [HCW-1:0]     hit_cnt_q, hit_cnt_d;
  logic               laser_kill_q, laser_kill_d;
  logic [2:0]         missile_kill_q, missile_kill_d;
  logic               wave_clear_q, wave_clear_d;

  logic [CODE_W-1:0]  pend_inv;
  logic [2:0]         pend_mis;
  logic [CODE_W-1:0]  inv_idx;
  logic [63:0]        inv_ext;
  logic               inv_hit;
  logic               vulnerable;
  logic               lost_last;
  logic [SCORE_W:0]   score_sum;

  collision_resolver_latch #(.N(N)) u_latch (
    .clk               (clk),
    .rst               (rst),
    .clear             (frame),
    .flush             (new_game),
    .mask              (inv_q),
    .invader_collision (invader_collision),
    .player_collision  (player_collision),
    .pend_inv          (pend_inv),
    .pend_mis          (pend_mis)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_PLAY;
      inv_q          <= '1;
      score_q        <= '0;
      lives_q        <= 3'(LIVES_INIT);
      hit_cnt_q      <= '0;
      laser_kill_q   <= 1'b0;
      missile_kill_q <= '0;
      wave_clear_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      inv_q          <= inv_d;
      score_q        <= score_d;
      lives_q        <= lives_d;
      hit_cnt_q      <= hit_cnt_d;
      laser_kill_q   <= laser_kill_d;
      missile_kill_q <= missile_kill_d;
      wave_clear_q   <= wave_clear_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    inv_d          = inv_q;
    score_d        = score_q;
    lives_d        = lives_q;
    hit_cnt_d      = hit_cnt_q;
    laser_kill_d   = 1'b0;
    missile_kill_d = '0;
    wave_clear_d   = 1'b0;
    lost_last      = 1'b0;
    mask_after     = inv_q;
    inv_idx        = pend_inv - 6'd1;
    inv_ext        = 64'(inv_q);
    // Re-check the mask: a code latched on a commit cycle may target an invader that commit removed.
    inv_hit        = (pend_inv != '0) && inv_ext[inv_idx];
    score_sum      = {1'b0, score_q} + (SCORE_W+1)'(row_points(pend_inv, INVADERS_H));
    // CLEAR remembers its prior state only through hit_cnt, so zero means it came from PLAY.
    vulnerable     = (state_q == ST_PLAY) || (state_q == ST_CLEAR && hit_cnt_q == '0);

    if (new_game) begin
      state_d   = ST_PLAY;
      inv_d     = '1;
      score_d   = '0;
      lives_d   = 3'(LIVES_INIT);
      hit_cnt_d = '0;
    end else if (frame && state_q != ST_OVER) begin
      if (inv_hit) begin
        mask_after[inv_idx] = 1'b0;
        laser_kill_d        = 1'b1;
        score_d             = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
      end
      missile_kill_d = pend_mis;
      if (hit_cnt_q != '0)
        hit_cnt_d = hit_cnt_q - HCW'(1);
      if (vulnerable && pend_mis != '0) begin
        if (lives_q != 3'd0)
          lives_d = lives_q - 3'd1;
        if (lives_d == 3'd0)
          lost_last = 1'b1;
        else
          hit_cnt_d = HCW'(HIT_FRAMES);
      end
      inv_d = mask_after;
      if (lost_last) begin
        state_d = ST_OVER;
      end else if (state_q == ST_CLEAR) begin
        inv_d        = '1;
        wave_clear_d = 1'b1;
        state_d      = (hit_cnt_d != '0) ? ST_HIT : ST_PLAY;
      end else if (mask_after == '0) begin
        state_d = ST_CLEAR;
      end else begin
        state_d = (hit_cnt_d != '0) ? ST_HIT : ST_PLAY;
      end
    end
  end

  assign invaders     = inv_q;
  assign laser_kill   = laser_kill_q;
  assign missile_kill = missile_kill_q;
  assign lives        = lives_q;
  assign score        = score_q;
  assign player_hit   = (state_q == ST_HIT);
  assign game_over    = (state_q == ST_OVER);
  assign wave_clear   = wave_clear_q;

endmodule

// File: tb/tb_collision_resolver.sv
// tb/tb_collision_resolver.sv - directed self-checking bench for collision_resolver
module tb_collision_resolver;

  logic        clk = 1'b0;
  logic        rst;
  logic        frame;
  logic        new_game;
  logic [5:0]  invader_collision;
  logic [1:0]  player_collision;
  logic [54:0] invaders;
  logic        laser_kill;
  logic [2:0]  missile_kill;
  logic [2:0]  lives;
  logic [15:0] score;
  logic        player_hit;
  logic        game_over;
  logic        wave_clear;

  int checks = 0;
  int passed = 0;
  int failed = 0;

  localparam logic [54:0] ALL_ALIVE = {55{1'b1}};
  localparam logic [54:0] ONLY_55   = 55'h40_0000_0000_0000;

  collision_resolver dut (
    .clk               (clk),
    .rst               (rst),
    .frame             (frame),
    .new_game          (new_game),
    .invader_collision (invader_collision),
    .player_collision  (player_collision),
    .invaders          (invaders),
    .laser_kill        (laser_kill),
    .missile_kill      (missile_kill),
    .lives             (lives),
    .score             (score),
    .player_hit        (player_hit),
    .game_over         (game_over),
    .wave_clear        (wave_clear)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_frame();
    frame = 1'b1;
    step();
    frame = 1'b0;
  endtask

  task automatic idle_frames(input int n);
    for (int i = 0; i < n; i++) begin
      pulse_frame();
      step();
    end
  endtask

  initial begin
    rst = 1'b1;
    frame = 1'b0;
    new_game = 1'b0;
    invader_collision = '0;
    player_collision = '0;
    step();
    step();
    rst = 1'b0;
    step();

    check("rst_invaders", 64'(invaders), 64'(ALL_ALIVE));
    check("rst_lives", 64'(lives), 64'd3);
    check("rst_score", 64'(score), 64'd0);
    check("rst_laser_kill", 64'(laser_kill), 64'd0);
    check("rst_missile_kill", 64'(missile_kill), 64'd0);
    check("rst_player_hit", 64'(player_hit), 64'd0);
    check("rst_game_over", 64'(game_over), 64'd0);
    check("rst_wave_clear", 64'(wave_clear), 64'd0);

    // first hit wins: code 12 held many cycles, code 5 afterwards is ignored
    invader_collision = 6'd12;
    repeat (40) step();
    invader_collision = 6'd5;
    step();
    invader_collision = 6'd0;
    pulse_frame();
    check("hit12_bit11", 64'(invaders[11]), 64'd0);
    check("hit12_bit4", 64'(invaders[4]), 64'd1);
    check("hit12_score", 64'(score), 64'd20);
    check("hit12_laser_kill", 64'(laser_kill), 64'd1);
    step();
    check("hit12_laser_kill_drop", 64'(laser_kill), 64'd0);

    // player hit and invulnerability window
    player_collision = 2'd2;
    step();
    player_collision = 2'd0;
    pulse_frame();
    check("phit_missile_kill", 64'(missile_kill), 64'h2);
    check("phit_lives", 64'(lives), 64'd2);
    check("phit_player_hit", 64'(player_hit), 64'd1);
    step();
    check("phit_missile_kill_drop", 64'(missile_kill), 64'd0);
    idle_frames(58);
    player_collision = 2'd1;
    step();
    player_collision = 2'd0;
    pulse_frame();
    check("invuln_lives", 64'(lives), 64'd2);
    check("invuln_missile_kill", 64'(missile_kill), 64'h1);
    check("invuln_player_hit_59", 64'(player_hit), 64'd1);
    step();
    pulse_frame();
    check("invuln_player_hit_60", 64'(player_hit), 64'd0);
    step();

    // wipe the wave: 11*30 + 21*20 + 21*10 on top of 20 gives 980
    for (int code = 1; code <= 54; code++) begin
      if (code != 12) begin
        invader_collision = 6'(code);
        step();
        invader_collision = 6'd0;
        pulse_frame();
        step();
      end
    end
    check("wave_mask_one_left", 64'(invaders), 64'(ONLY_55));
    check("wave_score_980", 64'(score), 64'd980);
    invader_collision = 6'd55;
    step();
    invader_collision = 6'd0;
    pulse_frame();
    check("wave_score_990", 64'(score), 64'd990);
    check("wave_mask_empty", 64'(invaders), 64'd0);
    check("wave_clear_not_yet", 64'(wave_clear), 64'd0);
    step();
    pulse_frame();
    check("wave_refill", 64'(invaders), 64'(ALL_ALIVE));
    check("wave_clear_pulse", 64'(wave_clear), 64'd1);
    step();
    check("wave_clear_drop", 64'(wave_clear), 64'd0);
    check("wave_player_hit", 64'(player_hit), 64'd0);

    // code arriving with frame belongs to the next frame
    invader_collision = 6'd3;
    frame = 1'b1;
    step();
    invader_collision = 6'd0;
    frame = 1'b0;
    check("sameframe_score_hold", 64'(score), 64'd990);
    check("sameframe_bit2_hold", 64'(invaders[2]), 64'd1);
    step();
    pulse_frame();
    check("sameframe_score_next", 64'(score), 64'd1020);
    check("sameframe_bit2_next", 64'(invaders[2]), 64'd0);
    step();

    // async reset mid-frame discards the pending hit
    invader_collision = 6'd1;
    step();
    invader_collision = 6'd0;
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    check("arst_score", 64'(score), 64'd0);
    check("arst_invaders", 64'(invaders), 64'(ALL_ALIVE));
    step();
    pulse_frame();
    check("arst_latch_dropped", 64'(invaders), 64'(ALL_ALIVE));
    check("arst_laser_kill", 64'(laser_kill), 64'd0);
    step();

    // three separated hits end the game
    for (int h = 0; h < 3; h++) begin
      player_collision = 2'd3;
      step();
      player_collision = 2'd0;
      pulse_frame();
      check("over_lives", 64'(lives), 64'(2 - h));
      if (h < 2) begin
        step();
        idle_frames(60);
        check("over_player_hit_recover", 64'(player_hit), 64'd0);
      end
    end
    check("over_game_over", 64'(game_over), 64'd1);
    check("over_missile_kill", 64'(missile_kill), 64'h4);
    check("over_player_hit", 64'(player_hit), 64'd0);
    step();
    invader_collision = 6'd7;
    player_collision = 2'd1;
    step();
    invader_collision = 6'd0;
    player_collision = 2'd0;
    pulse_frame();
    check("over_frozen_mask", 64'(invaders), 64'(ALL_ALIVE));
    check("over_frozen_score", 64'(score), 64'd0);
    check("over_frozen_laser", 64'(laser_kill), 64'd0);
    check("over_frozen_missile", 64'(missile_kill), 64'd0);
    check("over_frozen_lives", 64'(lives), 64'd0);
    step();

    new_game = 1'b1;
    step();
    new_game = 1'b0;
    check("newgame_lives", 64'(lives), 64'd3);
    check("newgame_game_over", 64'(game_over), 64'd0);
    check("newgame_score", 64'(score), 64'd0);
    check("newgame_invaders", 64'(invaders), 64'(ALL_ALIVE));

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
